// File: rtl/twenty_bit_or_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// twenty_bit_or_arbiter_pkg
// Shared definitions for the twenty-bit OR arbiter:
//   - `ST_IDLE / `ST_RESP : FSM encodings
//   - `DW                 : datapath width (20)
//   - state_t             : typed FSM state built on the encodings above
//   - DW                  : datapath width as a package localparam
// No ports (package only).
// ----------------------------------------------------------------------------
`ifndef TWENTY_BIT_OR_ARBITER_DEFS
`define TWENTY_BIT_OR_ARBITER_DEFS
`define ST_IDLE 1'b0
`define ST_RESP 1'b1
`define DW 20
`endif

package twenty_bit_or_arbiter_pkg;

   localparam int DW = `DW;

   typedef enum logic {
      ST_IDLE = `ST_IDLE,
      ST_RESP = `ST_RESP
   } state_t;

endpackage

// File: rtl/twenty_bit_bitwise_or.sv
// ----------------------------------------------------------------------------
// twenty_bit_bitwise_or
// Purely combinational 20-bit bitwise OR.
// Ports:
//   i0 : input  [DW-1:0]  operand A
//   i1 : input  [DW-1:0]  operand B
//   s  : output [DW-1:0]  i0 | i1
// ----------------------------------------------------------------------------
module twenty_bit_bitwise_or
   import twenty_bit_or_arbiter_pkg::*;
(
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   output logic [DW-1:0] s
);

   assign s = i0 | i1;

endmodule

// File: rtl/twenty_bit_or_arbiter.sv
// ----------------------------------------------------------------------------
// twenty_bit_or_arbiter
// Round-robin arbiter sharing one 20-bit OR unit among NUM_REQ requesters.
// One operand pair is accepted per grant; the result is registered and
// returned one cycle later tagged with the requester index.
// Ports:
//   clk        : input             system clock (rising edge)
//   rst_n      : input             asynchronous active-low reset
//   req_valid  : input  [NUM_REQ]  per-requester operand valid
//   req_ready  : output [NUM_REQ]  per-requester accept, one-hot or zero
//   req_a      : input  [NUM_REQ*20] operand A, requester k at [20k+19:20k]
//   req_b      : input  [NUM_REQ*20] operand B, same packing
//   rsp_valid  : output            result valid
//   rsp_ready  : input             consumer accepts result
//   rsp_data   : output [20]       registered a|b of the granted request
//   rsp_id     : output [ID_W]     requester index of rsp_data
//   op_count   : output [CNT_W]    completed responses, wrapping
// ----------------------------------------------------------------------------
module twenty_bit_or_arbiter
   import twenty_bit_or_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*DW-1:0] req_a,
   input  logic [NUM_REQ*DW-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DW-1:0]         rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic [CNT_W-1:0]      op_count
);

   state_t          state_reg, state_next;
   logic [ID_W-1:0] rr_ptr_reg;
   logic [DW-1:0]   rsp_data_reg;
   logic [ID_W-1:0] rsp_id_reg;
   logic [CNT_W-1:0] op_count_reg;

   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] idx;
   logic            no_grant;
   logic            can_accept;
   logic            accept;
   logic            rsp_done;
   logic [DW-1:0]   a_mux, b_mux, or_out;

   // Round-robin search starting at rr_ptr. Walking the offsets from the
   // far end back to zero lets the closest valid requester overwrite the
   // others, so the last assignment is the winner. NUM_REQ is a power of
   // two, so the ID_W-bit add wraps modulo NUM_REQ by itself.
   always_comb begin
      grant    = '0;
      no_grant = 1'b1;
      idx      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = rr_ptr_reg + ID_W'(i);
         if (req_valid[idx]) begin
            grant    = idx;
            no_grant = 1'b0;
         end
      end
   end

   assign can_accept = (state_reg == ST_IDLE) || ((state_reg == ST_RESP) && rsp_ready);
   // Reset gates the handshake so nothing is offered while rst_n is low.
   assign accept     = rst_n && can_accept && !no_grant;
   assign rsp_valid  = (state_reg == ST_RESP);
   assign rsp_done   = rsp_valid && rsp_ready;

   always_comb begin
      req_ready        = '0;
      req_ready[grant] = accept;
   end

   assign a_mux = req_a[grant*DW +: DW];
   assign b_mux = req_b[grant*DW +: DW];

   twenty_bit_bitwise_or u_or (
      .i0 (a_mux),
      .i1 (b_mux),
      .s  (or_out)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = ST_RESP;
         ST_RESP: begin
            if (accept)         state_next = ST_RESP;
            else if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         rr_ptr_reg   <= '0;
         rsp_data_reg <= '0;
         rsp_id_reg   <= '0;
         op_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rsp_data_reg <= or_out;
            rsp_id_reg   <= grant;
            rr_ptr_reg   <= grant + ID_W'(1);
         end
         // An accept overlapping a response handshake is still one completion.
         if (rsp_done) op_count_reg <= op_count_reg + CNT_W'(1);
      end
   end

   assign rsp_data = rsp_data_reg;
   assign rsp_id   = rsp_id_reg;
   assign op_count = op_count_reg;

endmodule

// File: tb/tb_twenty_bit_or_arbiter.sv
// ----------------------------------------------------------------------------
// tb_twenty_bit_or_arbiter
// Directed bench for twenty_bit_or_arbiter (NUM_REQ=4, CNT_W=4 so the
// counter wrap is reachable quickly). Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_twenty_bit_or_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 4;
   localparam int DW      = 20;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*DW-1:0] req_a;
   logic [NUM_REQ*DW-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DW-1:0]         rsp_data;
   logic [ID_W-1:0]       rsp_id;
   logic [CNT_W-1:0]      op_count;

   int errors = 0;
   int checks = 0;

   twenty_bit_or_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      rst_n = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready_in_reset: got %b want 0000", req_ready);
      end
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 20'h00000 || rsp_id !== 2'd0 ||
          op_count !== 4'd0 || req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: got v=%b d=%h id=%0d cnt=%0d rdy=%b want 0 00000 0 0 0000",
                  rsp_valid, rsp_data, rsp_id, op_count, req_ready);
      end
      $display("test_reset: idle state checked");
   endtask

   task automatic test_single();
      req_valid = 4'b0001;
      req_a[19:0] = 20'h0005F;
      req_b[19:0] = 20'h00000;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_ready: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 20'h0005F || rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL single_rsp: got v=%b d=%h id=%0d want 1 0005f 0", rsp_valid, rsp_data, rsp_id);
      end
      tick();
      checks++;
      if (op_count !== 4'd1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL single_count: got cnt=%0d v=%b want 1 0", op_count, rsp_valid);
      end
      $display("test_single: a=0005f b=00000 -> %h id=%0d", rsp_data, rsp_id);
   endtask

   task automatic test_contention();
      logic [3:0]  exp_rdy;
      logic [19:0] exp_d;
      do_reset();
      for (int k = 0; k < NUM_REQ; k++) begin
         req_a[k*DW +: DW] = 20'(k);
         req_b[k*DW +: DW] = 20'hC0000;
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #1;
         exp_rdy = 4'b0001 << (j % 4);
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL contention_grant%0d: got %b want %b", j, req_ready, exp_rdy);
         end
         tick();
         exp_d = 20'hC0000 | 20'(j % 4);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'(j % 4)) begin
            errors++;
            $display("FAIL contention_rsp%0d: got v=%b d=%h id=%0d want 1 %h %0d",
                     j, rsp_valid, rsp_data, rsp_id, exp_d, j % 4);
         end
         $display("test_contention: op %0d -> %h id=%0d", j, rsp_data, rsp_id);
      end
      req_valid = '0;
      tick();
      checks++;
      if (op_count !== 4'd5 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL contention_count: got cnt=%0d v=%b want 5 0", op_count, rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      // rr_ptr is 1 here; only requester 3 asks, so it wins and rr_ptr -> 0.
      req_a[3*DW +: DW] = 20'hC0003;
      req_b[3*DW +: DW] = 20'hC0003;
      req_a[1*DW +: DW] = 20'h12300;
      req_b[1*DW +: DW] = 20'h00045;
      req_valid = 4'b1000;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL bp_first_grant: got %b want 1000", req_ready);
      end
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 20'hC0003 || rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b want 1 c0003 3 0000",
                     c, rsp_valid, rsp_data, rsp_id, req_ready);
         end
         $display("test_backpressure: hold cycle %0d d=%h rdy=%b", c, rsp_data, req_ready);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL bp_release_grant: got %b want 0010", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 20'h12345 || rsp_id !== 2'd1) begin
         errors++;
         $display("FAIL bp_release_rsp: got v=%b d=%h id=%0d want 1 12345 1", rsp_valid, rsp_data, rsp_id);
      end
      tick();
      checks++;
      if (op_count !== 4'd7) begin
         errors++; $display("FAIL bp_count: got %0d want 7", op_count);
      end
   endtask

   task automatic test_reset_in_resp();
      do_reset();
      req_a[19:0] = 20'hFFFFF;
      req_b[19:0] = 20'h00000;
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 20'hFFFFF) begin
         errors++; $display("FAIL rr_setup: got v=%b d=%h want 1 fffff", rsp_valid, rsp_data);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 20'h00000) begin
         errors++; $display("FAIL rr_async: got v=%b d=%h want 0 00000", rsp_valid, rsp_data);
      end
      tick();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (op_count !== 4'd0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rr_count: got cnt=%0d v=%b want 0 0", op_count, rsp_valid);
      end
      // rr_ptr back at 0: with 0 and 3 both asking, 0 must win.
      req_valid = 4'b1001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL rr_ptr_zero: got %b want 0001", req_ready);
      end
      tick();
      req_valid = 4'b1000;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL rr_grant3: got %b want 1000", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_id !== 2'd3 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL rr_rsp3: got id=%0d v=%b want 3 1", rsp_id, rsp_valid);
      end
      tick();
      $display("test_reset_in_resp: after release grant id=%0d cnt=%0d", rsp_id, op_count);
   endtask

   task automatic test_wrap();
      do_reset();
      rsp_ready = 1'b1;
      for (int n = 0; n < 15; n++) begin
         req_valid = 4'b0001;
         tick();
         req_valid = '0;
         tick();
      end
      checks++;
      if (op_count !== 4'd15) begin
         errors++; $display("FAIL wrap_preload: got %0d want 15", op_count);
      end
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (op_count !== 4'd0) begin
         errors++; $display("FAIL wrap_zero: got %0d want 0", op_count);
      end
      $display("test_wrap: count after 16 handshakes = %0d", op_count);
   endtask

   initial begin
      rst_n = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_in_resp();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
